// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer and
// the decode/stall logic that drives it.
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, FINISH} md_state_e;

  localparam logic [4:0] ALU_OP_ADD    = 5'b00000;
  localparam logic [4:0] ALU_OP_SUB    = 5'b00001;
  localparam int         MULTDIV_ITERS = 32;
endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter for the multiply/divide sequencer; term flags the last
// iteration (count == WIDTH-1).
module multdiv_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign term = (cnt_q == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) using the shared ALU.
// Build option: MULTDIV_EARLY_DIV0_EN completes divide-by-zero one cycle after start.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULTDIV_ITERS,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  output logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d, m_q, m_d, res_q, res_d;
  logic             q1_q, q1_d, is_div_q, is_div_d, neg_q, neg_d, div0_q, div0_d;
  logic             exc_q, exc_d, rdy_q, rdy_d;
  logic             cnt_clr, cnt_en, cnt_term;
  logic             start_ok, start_mul, start_div, alu_sign, take;
  logic [WIDTH-1:0] a_mag, b_mag, r_shift, q_neg;

  multdiv_iter_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term)
  );

  assign start_ok  = (state_q == IDLE) && !rdy_q;
  assign start_mul = start_ok && ctrl_MULT;
  assign start_div = start_ok && ctrl_DIV && !ctrl_MULT;
  assign a_mag     = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign b_mag     = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
  assign q_neg     = ~p_lo_q + 1'b1;
  assign r_shift   = {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]};
  assign alu_sign  = alu_result[WIDTH-1] ^ alu_overflow;
  // A divisor with its top bit set can only be |0x80000000|; the signed ALU
  // compare misreads it as negative, so then only R' >= 2^(WIDTH-1) qualifies.
  assign take      = r_shift[WIDTH-1] | (~m_q[WIDTH-1] & ~alu_sign);

  always_comb begin
    state_d    = state_q;
    p_hi_d     = p_hi_q;
    p_lo_d     = p_lo_q;
    q1_d       = q1_q;
    m_d        = m_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    div0_d     = div0_q;
    res_d      = res_q;
    exc_d      = exc_q;
    rdy_d      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    alu_opA    = '0;
    alu_opB    = '0;
    alu_opcode = ALU_OP_ADD;
    case (state_q)
      IDLE: begin
        if (start_mul) begin
          state_d  = MUL_IT;
          p_hi_d   = '0;
          p_lo_d   = data_operandB;
          q1_d     = 1'b0;
          m_d      = data_operandA;
          is_div_d = 1'b0;
          cnt_clr  = 1'b1;
        end else if (start_div) begin
          state_d  = DIV_IT;
          p_hi_d   = '0;
          p_lo_d   = a_mag;
          m_d      = b_mag;
          is_div_d = 1'b1;
          neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          div0_d   = (data_operandB == '0);
          cnt_clr  = 1'b1;
`ifdef MULTDIV_EARLY_DIV0_EN
          if (data_operandB == '0) state_d = FINISH;
`endif
        end
      end
      MUL_IT: begin
        alu_opA = p_hi_q;
        case ({p_lo_q[0], q1_q})
          2'b10: begin alu_opcode = ALU_OP_SUB; alu_opB = m_q; end
          2'b01: alu_opB = m_q;
          default: ;
        endcase
        // 33-bit sign recovered from overflow keeps the arithmetic shift exact.
        p_hi_d = {alu_sign, alu_result[WIDTH-1:1]};
        p_lo_d = {alu_result[0], p_lo_q[WIDTH-1:1]};
        q1_d   = p_lo_q[0];
        cnt_en = 1'b1;
        if (cnt_term) state_d = FINISH;
      end
      DIV_IT: begin
        alu_opA    = r_shift;
        alu_opB    = m_q;
        alu_opcode = ALU_OP_SUB;
        p_hi_d     = take ? alu_result : r_shift;
        p_lo_d     = {p_lo_q[WIDTH-2:0], take};
        cnt_en     = 1'b1;
        if (cnt_term) state_d = FINISH;
      end
      FINISH: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
        if (!is_div_q) begin
          res_d = p_lo_q;
          exc_d = (p_hi_q != {WIDTH{p_lo_q[WIDTH-1]}});
        end else if (div0_q) begin
          res_d = '0;
          exc_d = 1'b1;
        end else begin
          // Only a positive quotient of 2^(WIDTH-1) is unrepresentable.
          res_d = neg_q ? q_neg : p_lo_q;
          exc_d = ~neg_q & p_lo_q[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != IDLE) || rdy_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with a behavioural combinational ALU.
module tb_multdiv_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] A, B;
  logic [31:0] alu_opA, alu_opB, alu_result, data_result;
  logic [4:0]  alu_opcode;
  logic        alu_overflow, data_exception, data_resultRDY, busy;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          div0_lat;

  always #5 clock = ~clock;

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(A), .data_operandB(B),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always_comb begin
    if (alu_opcode == 5'b00001) begin
      alu_result   = alu_opA - alu_opB;
      alu_overflow = (alu_opA[31] != alu_opB[31]) && (alu_result[31] != alu_opA[31]);
    end else begin
      alu_result   = alu_opA + alu_opB;
      alu_overflow = (alu_opA[31] == alu_opB[31]) && (alu_result[31] != alu_opA[31]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Start edge E0 followed by lat+3 observed edges; inj>0 re-pulses ctrl_DIV so it is sampled at E<inj>.
  task automatic run_op(input string tag, input logic mul, input logic div,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int lat, input int inj);
    int          first, nrdy;
    logic [31:0] res;
    logic        exc, busy_ok, opc_ok;
    first = 0; nrdy = 0; res = '0; exc = 1'b0; busy_ok = 1'b1; opc_ok = 1'b1;
    @(negedge clock);
    ctrl_MULT = mul; ctrl_DIV = div; A = a; B = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; A = $urandom; B = $urandom;
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= lat + 3; k++) begin
      if (alu_opcode > 5'd1) opc_ok = 1'b0;
      @(posedge clock); #1;
      if (data_resultRDY === 1'b1) begin
        nrdy++;
        if (first == 0) begin first = k; res = data_result; exc = data_exception; end
      end
      if (busy !== (k <= lat)) busy_ok = 1'b0;
      if (inj != 0 && k == inj - 1) begin ctrl_DIV = 1'b1; A = 32'd100; B = 32'd3; end
      if (inj != 0 && k == inj) ctrl_DIV = 1'b0;
    end
    chk({tag, ".latency"}, 32'(first), 32'(lat));
    chk({tag, ".rdy_cycles"}, 32'(nrdy), 32'd1);
    chk({tag, ".result"}, res, exp_res);
    chk({tag, ".exception"}, {31'b0, exc}, {31'b0, exp_exc});
    chk({tag, ".busy"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, ".opcode"}, {31'b0, opc_ok}, 32'd1);
  endtask

  initial begin
`ifdef MULTDIV_EARLY_DIV0_EN
    div0_lat = 1;
`else
    div0_lat = 33;
`endif
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.result", data_result, 32'h0);
    chk("reset.rdy_exc_busy", {29'b0, data_resultRDY, data_exception, busy}, 32'h0);
    chk("reset.alu_opA", alu_opA, 32'h0);
    chk("reset.alu_op_opB", {alu_opcode, alu_opB[26:0]}, 32'h0);
    reset = 1'b0;

    run_op("mul_7_m3",        1, 0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 0, 33, 0);
    run_op("mul_ovf_2p32",    1, 0, 32'h00010000,   32'h00010000, 32'h00000000, 1, 33, 0);
    run_op("mul_min_m1",      1, 0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1, 33, 0);
    run_op("mul_m5_m6",       1, 0, 32'hFFFFFFFB,   32'hFFFFFFFA, 32'd30,       0, 33, 0);
    run_op("mul_min_1",       1, 0, 32'h80000000,   32'd1,        32'h80000000, 0, 33, 0);
    run_op("div_m7_2",        0, 1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 0, 33, 0);
    run_op("div_100_min",     0, 1, 32'd100,        32'h80000000, 32'h00000000, 0, 33, 0);
    run_op("div_min_2",       0, 1, 32'h80000000,   32'd2,        32'hC0000000, 0, 33, 0);
    run_op("div_100_7",       0, 1, 32'd100,        32'd7,        32'd14,       0, 33, 0);
    run_op("div_5_0",         0, 1, 32'd5,          32'd0,        32'h00000000, 1, div0_lat, 0);
    run_op("div_min_m1",      0, 1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1, 33, 0);
    run_op("both_6_4_inj5",   1, 1, 32'd6,          32'd4,        32'd24,       0, 33, 5);

    // Reset asserted so that it is sampled at E10 of a multiply.
    @(negedge clock);
    ctrl_MULT = 1'b1; A = 32'd3; B = 32'd5;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort.result", data_result, 32'h0);
    chk("abort.rdy_exc_busy", {29'b0, data_resultRDY, data_exception, busy}, 32'h0);
    chk("abort.alu_opA", alu_opA, 32'h0);
    begin
      int nrdy;
      nrdy = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clock); #1;
        if (data_resultRDY === 1'b1) nrdy++;
      end
      chk("abort.no_rdy", 32'(nrdy), 32'd0);
    end
    run_op("post_abort_mul",  1, 0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 0, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
